// File: rtl/vga_fb_scheduler.sv
// Time-multiplexes one single-port double-buffered framebuffer RAM between 640x480 scan-out and a pixel writer.
// Pixel latency is a fixed 3 cycles from pos sample; the writer is stalled (wr_ready low) for the whole active region.
module vga_fb_scheduler #(
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int DW          = 12,
    parameter int AW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [7:0]    wr_x,
    input  logic [6:0]    wr_y,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic          flip_req,
    output logic          flip_pending,
    output logic          front_page,
    output logic          flip_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int          PAGE = FB_W * FB_H;
    localparam logic [9:0]  HS   = 10'(H_ACT_START);
    localparam logic [9:0]  HE   = 10'(H_ACT_END);
    localparam logic [9:0]  VS   = 10'(V_ACT_START);
    localparam logic [9:0]  VE   = 10'(V_ACT_END);

    typedef enum logic {SHOWING, PENDING} flip_state_t;

    flip_state_t   state, state_nxt;
    logic          apply;
    logic          active;
    logic          wr_in_range;
    logic          rd_s1, rd_s2;
    logic [AW-1:0] front_base, back_base;
    logic [AW-1:0] rd_row, rd_col, rd_addr, wr_addr;

    assign active      = (pos_x >= HS) && (pos_x < HE) && (pos_y >= VS) && (pos_y < VE);
    assign wr_ready    = !active && !rst;
    assign wr_in_range = (AW'(wr_x) < AW'(FB_W)) && (AW'(wr_y) < AW'(FB_H));

    // All address terms are AW wide so the page offset never truncates
    assign front_base = front_page ? AW'(PAGE) : '0;
    assign back_base  = front_page ? '0 : AW'(PAGE);
    assign rd_row     = (AW'(pos_y) - AW'(V_ACT_START)) >> SCALE_SHIFT;
    assign rd_col     = (AW'(pos_x) - AW'(H_ACT_START)) >> SCALE_SHIFT;
    assign rd_addr    = front_base + rd_row * AW'(FB_W) + rd_col;
    assign wr_addr    = back_base + AW'(wr_y) * AW'(FB_W) + AW'(wr_x);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_err    <= 1'b0;
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            wr_err    <= 1'b0;
            rd_s1     <= active;
            rd_s2     <= rd_s1;
            pix_valid <= rd_s2;
            pix_data  <= rd_s2 ? mem_rdata : '0;
            if (active) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= rd_addr;
            end else if (wr_valid && wr_in_range) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else begin
                // Idle and dropped writes both leave address/data lines untouched
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                wr_err <= wr_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SHOWING;
            front_page <= 1'b0;
            flip_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            front_page <= front_page ^ apply;
            flip_done  <= apply;
        end
    end

    // Swap only at the start of vertical front porch so a frame is never torn
    always_comb begin
        state_nxt = state;
        apply     = 1'b0;
        case (state)
            SHOWING: if (flip_req) state_nxt = PENDING;
            PENDING: if (pos_y == VE && pos_x == 10'd0) begin
                apply     = 1'b1;
                state_nxt = SHOWING;
            end
        endcase
    end

    always_comb begin
        flip_pending = (state == PENDING);
    end

endmodule
